smult_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one signed multiplier (`smult`) among `NREQ` requesters. Each requester offers an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, registers the winning operands into an issue stage, and drives the multiplier. A tag pipeline runs alongside the multiplier latency so each product returns with its requester ID. Sits between independent DSP-consuming clients and a single multiplier instance.

---
 rtl/smult_arb_if.sv | 34 +++
 rtl/smult_arb.sv | 203 ++++++++++++++++++++
 tb/tb_smult_arb.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/smult_arb_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : smult_arb_if
// | Description : Requester/result bundle between DSP clients and smult_arb.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
interface smult_arb_if #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 8,
  parameter int BWIDTH = 8,
  parameter int OWIDTH = AWIDTH + BWIDTH
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*AWIDTH-1:0] req_a;
  logic [NREQ*BWIDTH-1:0] req_b;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic [OWIDTH-1:0]      res_data;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/smult_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : smult_arb (with helper smult)
// | Description : Round-robin arbiter sharing one signed multiplier among NREQ
// |               requesters; tags each product with its requester ID.
// |               Define SMULT_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------

module smult #(
  parameter int AWIDTH   = 8,
  parameter int BWIDTH   = 8,
  parameter int PIPELINE = 1
) (
  input  wire                             clk,
  input  wire                             rst_n,
  input  wire  signed [AWIDTH-1:0]        a,
  input  wire  signed [BWIDTH-1:0]        b,
  output logic signed [AWIDTH+BWIDTH-1:0] p
);
  localparam int PW = AWIDTH + BWIDTH;

  logic signed [PW-1:0] w_prod;

  assign w_prod = a * b;

  if (PIPELINE == 0) begin : g_comb
    logic w_unused;
    assign w_unused = clk ^ rst_n;
    assign p = w_prod;
  end else begin : g_reg
    logic signed [PW-1:0] r_pipe [PIPELINE];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPELINE; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_prod;
        for (int i = 1; i < PIPELINE; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign p = r_pipe[PIPELINE-1];
  end
endmodule

module smult_arb #(
  parameter int NREQ     = 4,
  parameter int AWIDTH   = 8,
  parameter int BWIDTH   = 8,
  parameter int PIPELINE = 1,
  parameter int OWIDTH   = AWIDTH + BWIDTH
) (
  input  wire       clk,
  input  wire       rst_n,
  smult_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  if (PIPELINE < 0 || PIPELINE > 2) begin : g_bad_pipeline
    $fatal(1, "smult_arb: PIPELINE must be 0, 1 or 2");
  end
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $fatal(1, "smult_arb: NREQ must be in 2..16");
  end
  if (OWIDTH != AWIDTH + BWIDTH) begin : g_bad_owidth
    $fatal(1, "smult_arb: OWIDTH must equal AWIDTH+BWIDTH");
  end

  logic [NREQ-1:0]          w_gnt;
  logic [IDW-1:0]           w_gnt_id;
  logic [IDW-1:0]           w_idx;
  logic [IDW-1:0]           w_start;
  logic                     w_found;
  logic                     w_acc;
  logic signed [AWIDTH-1:0] w_sel_a;
  logic signed [BWIDTH-1:0] w_sel_b;
  logic signed [OWIDTH-1:0] w_prod;

  logic signed [AWIDTH-1:0] r_iss_a;
  logic signed [BWIDTH-1:0] r_iss_b;
  logic [IDW-1:0]           r_iss_id;
  logic                     r_iss_v;

  logic                     w_tag_v;
  logic [IDW-1:0]           w_tag_id;
  logic                     w_tag_busy;

  logic                     r_res_valid;
  logic [IDW-1:0]           r_res_id;
  logic signed [OWIDTH-1:0] r_res_data;

`ifdef SMULT_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IDW-1:0] r_ptr;

  assign w_start = r_ptr;

  // Pointer moves just past the winner so it becomes lowest priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_acc) begin
      r_ptr <= (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);
    end
  end
`endif

  always_comb begin
    w_gnt    = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(w_start) + k) % NREQ);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found      = 1'b1;
        w_gnt_id     = w_idx;
        w_gnt[w_idx] = 1'b1;
      end
    end
  end

  assign w_acc         = w_found;
  assign bus.req_ready = rst_n ? w_gnt : '0;
  assign w_sel_a       = bus.req_a[w_gnt_id*AWIDTH +: AWIDTH];
  assign w_sel_b       = bus.req_b[w_gnt_id*BWIDTH +: BWIDTH];

  // Operands hold their last value when idle; only the valid bit drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_a  <= '0;
      r_iss_b  <= '0;
      r_iss_id <= '0;
      r_iss_v  <= 1'b0;
    end else begin
      r_iss_v <= w_acc;
      if (w_acc) begin
        r_iss_a  <= w_sel_a;
        r_iss_b  <= w_sel_b;
        r_iss_id <= w_gnt_id;
      end
    end
  end

  smult #(
    .AWIDTH   (AWIDTH),
    .BWIDTH   (BWIDTH),
    .PIPELINE (PIPELINE)
  ) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (r_iss_a),
    .b     (r_iss_b),
    .p     (w_prod)
  );

  if (PIPELINE == 0) begin : g_tag_none
    assign w_tag_v    = r_iss_v;
    assign w_tag_id   = r_iss_id;
    assign w_tag_busy = 1'b0;
  end else begin : g_tag_pipe
    logic [PIPELINE-1:0] r_tag_v;
    logic [IDW-1:0]      r_tag_id [PIPELINE];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tag_v <= '0;
        for (int i = 0; i < PIPELINE; i++) r_tag_id[i] <= '0;
      end else begin
        r_tag_v[0]  <= r_iss_v;
        r_tag_id[0] <= r_iss_id;
        for (int i = 1; i < PIPELINE; i++) begin
          r_tag_v[i]  <= r_tag_v[i-1];
          r_tag_id[i] <= r_tag_id[i-1];
        end
      end
    end

    assign w_tag_v    = r_tag_v[PIPELINE-1];
    assign w_tag_id   = r_tag_id[PIPELINE-1];
    assign w_tag_busy = |r_tag_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
    end else begin
      r_res_valid <= w_tag_v;
      r_res_id    <= w_tag_v ? w_tag_id : '0;
      r_res_data  <= w_tag_v ? w_prod : '0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.res_data  = r_res_data;
  assign bus.busy      = r_iss_v | w_tag_busy;
endmodule
`default_nettype wire

// File: tb/tb_smult_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : tb_smult_arb
// | Description : Randomized bench driving three smult_arb instances
// |               (PIPELINE 0/1/2) from shared requester queues.
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_smult_arb;
  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int BW   = 8;
  localparam int OW   = 16;
  localparam int IDW  = 2;
  localparam int MAXE = 4096;
  localparam int NDUT = 3;

  typedef struct packed {
    logic signed [AW-1:0] a;
    logic signed [BW-1:0] b;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    valid;
  logic [NREQ*AW-1:0] pa;
  logic [NREQ*BW-1:0] pb;

  logic [NREQ-1:0] ready [NDUT];
  logic            rv    [NDUT];
  logic [IDW-1:0]  rid   [NDUT];
  logic [OW-1:0]   rdata [NDUT];
  logic            bsy   [NDUT];

  for (genvar p = 0; p < NDUT; p++) begin : g_dut
    smult_arb_if #(.NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW)) bus ();
    assign bus.req_valid = valid;
    assign bus.req_a     = pa;
    assign bus.req_b     = pb;
    assign ready[p]      = bus.req_ready;
    assign rv[p]         = bus.res_valid;
    assign rid[p]        = bus.res_id;
    assign rdata[p]      = bus.res_data;
    assign bsy[p]        = bus.busy;

    smult_arb #(
      .NREQ(NREQ), .AWIDTH(AW), .BWIDTH(BW), .PIPELINE(p), .OWIDTH(OW)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Reference model state: requester queues and acceptance log by edge index.
  op_t q [NREQ][$];
  int  m_ptr = 0;
  int  e = 0;
  bit  acc_v  [MAXE];
  int  acc_id [MAXE];
  int  acc_p  [MAXE];
  int  errors = 0;
  int  checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input int a, input int b);
    op_t o;
    o.a = AW'(a);
    o.b = BW'(b);
    return o;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    int start;
`ifdef SMULT_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NREQ; k++)
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      valid[i] = (q[i].size() > 0);
      pa[i*AW +: AW] = valid[i] ? q[i][0].a : AW'($urandom);
      pb[i*BW +: BW] = valid[i] ? q[i][0].b : BW'($urandom);
    end
  endtask

  task automatic tick();
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = rst_n ? pick(valid, m_ptr) : -1;
    exp_rdy = (g >= 0) ? (NREQ'(1) << g) : '0;
    for (int p = 0; p < NDUT; p++) begin
      int k;
      bit ev;
      bit eb;
      int eid;
      int ep;
      ev = 1'b0; eb = 1'b0; eid = 0; ep = 0;
      k = e - 1 - (1 + p);
      if (k >= 0 && acc_v[k]) begin
        ev = 1'b1; eid = acc_id[k]; ep = acc_p[k];
      end
      for (int d = 0; d <= p; d++)
        if (e - 1 - d >= 0 && acc_v[e-1-d]) eb = 1'b1;
      check_eq($sformatf("ready p%0d c%0d", p, e), 32'(ready[p]), 32'(exp_rdy));
      check_eq($sformatf("res_valid p%0d c%0d", p, e), 32'(rv[p]), 32'(ev));
      check_eq($sformatf("res_id p%0d c%0d", p, e), 32'(rid[p]), 32'(eid));
      check_eq($sformatf("res_data p%0d c%0d", p, e), {16'h0, rdata[p]}, {16'h0, ep[15:0]});
      check_eq($sformatf("busy p%0d c%0d", p, e), 32'(bsy[p]), 32'(eb));
    end
    @(posedge clk);
    if (e >= MAXE - 1) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, MAXE - 1);
      $fatal(1, "edge budget exhausted");
    end
    if (g >= 0) begin
      acc_v[e]  = 1'b1;
      acc_id[e] = g;
      acc_p[e]  = int'(q[g][0].a) * int'(q[g][0].b);
      void'(q[g].pop_front());
      m_ptr = (g == NREQ - 1) ? 0 : g + 1;
    end
    e++;
    #1;
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_random(input int pct);
    for (int i = 0; i < NREQ; i++)
      if (q[i].size() < 3 && $urandom_range(99) < pct)
        q[i].push_back(mk(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128));
  endtask

  initial begin
    for (int j = 0; j < MAXE; j++) acc_v[j] = 1'b0;
    rst_n = 1'b0;
    // Requester 1 already valid in reset: ready must stay low until release.
    q[1].push_back(mk(-3, 7));
    drive();
    ticks(2);
    rst_n = 1'b1;
    ticks(5);

    // Corner operands; requester 3 last so the pointer wraps back to 0.
    q[2].push_back(mk(-128, -128));
    q[3].push_back(mk(127, -128));
    q[3].push_back(mk(0, -1));
    drive();
    ticks(6);

    // All four held valid for eight grants.
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 2; n++)
        q[i].push_back(mk(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128));
    drive();
    ticks(12);

    // Single requester holding valid is granted back to back.
    for (int n = 0; n < 4; n++) q[2].push_back(mk(n - 2, 5 * n - 9));
    drive();
    ticks(8);

    for (int c = 0; c < 250; c++) begin
      push_random(35);
      drive();
      tick();
    end
    ticks(8);

    // Three requests, then a one-cycle asynchronous reset in the middle.
    for (int i = 0; i < 3; i++) q[i].push_back(mk(11 * i + 3, -7 * i - 5));
    drive();
    ticks(2);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    for (int i = 0; i < NREQ; i++) q[i].push_back(mk(i + 1, -(i + 2)));
    for (int j = 0; j < MAXE; j++) acc_v[j] = 1'b0;
    m_ptr = 0;
    drive();
    tick();
    rst_n = 1'b1;
    ticks(8);

    for (int c = 0; c < 150; c++) begin
      push_random(70);
      drive();
      tick();
    end
    for (int i = 0; i < NREQ; i++) q[i].delete();
    drive();
    ticks(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
